// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 receiver definitions
// Purpose: frame FSM state encoding, scan-code prefix constants and a parity helper.
// Ports: none (package).
package ps2_pkg;

  // Frame FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // Scan-code prefix bytes
  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 frame receiver (sync, edge detect, frame FSM, timeout)
// Purpose: recovers bytes from the PS/2 clock/data pair and flags bad frames.
// Ports:
//   CLOCK_50   in   system clock
//   reset      in   synchronous active-high reset
//   ps2_clk    in   asynchronous PS/2 clock
//   ps2_dat    in   asynchronous PS/2 data
//   byte_data  out  last correctly received byte
//   byte_valid out  one-cycle pulse, byte_data is new
//   parity_err out  one-cycle pulse, frame dropped on parity
//   frame_err  out  one-cycle pulse, frame dropped on stop bit or timeout
module ps2_frame_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       parity_err,
  output logic       frame_err
);
  import ps2_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_prev;
  logic          fall;
  logic          dat_bit;
  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [TW-1:0] tcnt;

  assign fall    = clk_prev & ~clk_sync[1];
  assign dat_bit = dat_sync[1];

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_sync   <= 2'b11;
      dat_sync   <= 2'b11;
      clk_prev   <= 1'b1;
      state      <= ST_IDLE;
      bit_cnt    <= 3'd0;
      shift      <= 8'd0;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      byte_data  <= 8'd0;
      byte_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      dat_sync   <= {dat_sync[0], ps2_dat};
      clk_prev   <= clk_sync[1];
      byte_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;

      // Counts cycles since the last falling edge, only while a frame is open
      if (state == ST_IDLE || fall) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end

      if (fall) begin
        case (state)
          ST_IDLE: begin
            // A high bit here is line noise or a frame tail; only a 0 opens a frame
            if (!dat_bit) begin
              state   <= ST_DATA;
              bit_cnt <= 3'd0;
            end
          end
          ST_DATA: begin
            shift   <= {dat_bit, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            par_bit <= dat_bit;
            state   <= ST_STOP;
          end
          default: begin
            state <= ST_IDLE;
            // A bad stop bit outranks a parity failure
            if (!dat_bit) begin
              frame_err <= 1'b1;
            end else if (odd_parity_ok(shift, par_bit)) begin
              byte_data  <= shift;
              byte_valid <= 1'b1;
            end else begin
              parity_err <= 1'b1;
            end
          end
        endcase
      end else if (state != ST_IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state     <= ST_IDLE;
        bit_cnt   <= 3'd0;
        shift     <= 8'd0;
        frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_receiver.sv
// rtl/ps2_receiver.sv - PS/2 keyboard receiver with scan-code prefix decoder
// Purpose: turns PS/2 frames into key events (code, break, extended).
// Ports:
//   CLOCK_50     in   system clock
//   reset        in   synchronous active-high reset
//   ps2_clk      in   asynchronous PS/2 clock
//   ps2_dat      in   asynchronous PS/2 data
//   byte_data    out  last correctly received byte
//   byte_valid   out  one-cycle pulse, byte_data is new
//   parity_err   out  one-cycle pulse, frame dropped on parity
//   frame_err    out  one-cycle pulse, frame dropped on stop bit or timeout
//   key_code     out  scan code of last key event
//   key_release  out  last event was a break
//   key_extended out  last event was E0-prefixed
//   key_valid    out  one-cycle pulse, key_* fields are new
module ps2_receiver #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic [7:0] key_code,
  output logic       key_release,
  output logic       key_extended,
  output logic       key_valid
);
  import ps2_pkg::*;

  logic ext_flag;
  logic rel_flag;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ext_flag     <= 1'b0;
      rel_flag     <= 1'b0;
      key_code     <= 8'd0;
      key_release  <= 1'b0;
      key_extended <= 1'b0;
      key_valid    <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (parity_err || frame_err) begin
        // A lost byte may have been part of this event, so drop pending prefixes
        ext_flag <= 1'b0;
        rel_flag <= 1'b0;
      end else if (byte_valid) begin
        if (byte_data == PS2_PREFIX_EXT) begin
          ext_flag <= 1'b1;
        end else if (byte_data == PS2_PREFIX_BREAK) begin
          rel_flag <= 1'b1;
        end else begin
          key_code     <= byte_data;
          key_extended <= ext_flag;
          key_release  <= rel_flag;
          key_valid    <= 1'b1;
          ext_flag     <= 1'b0;
          rel_flag     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// tb/tb_ps2_receiver.sv - directed self-checking bench for ps2_receiver
module tb_ps2_receiver;

  localparam int TO   = 1000;
  localparam int HALF = 50;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       parity_err;
  logic       frame_err;
  logic [7:0] key_code;
  logic       key_release;
  logic       key_extended;
  logic       key_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int n_byte = 0, n_par = 0, n_frm = 0, n_key = 0, n_excl = 0, n_wide = 0;
  logic pv_byte = 1'b0, pv_par = 1'b0, pv_frm = 1'b0, pv_key = 1'b0;

  ps2_receiver #(.TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_dat     (ps2_dat),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .key_code    (key_code),
    .key_release (key_release),
    .key_extended(key_extended),
    .key_valid   (key_valid)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (reset !== 1'b1) begin
      if (byte_valid) n_byte++;
      if (parity_err) n_par++;
      if (frame_err)  n_frm++;
      if (key_valid)  n_key++;
      if (int'(byte_valid) + int'(parity_err) + int'(frame_err) > 1) n_excl++;
      if ((byte_valid && pv_byte) || (parity_err && pv_par) ||
          (frame_err && pv_frm) || (key_valid && pv_key)) n_wide++;
    end
    pv_byte = byte_valid;
    pv_par  = parity_err;
    pv_frm  = frame_err;
    pv_key  = key_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par,
                                             input logic stop);
    return {stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge CLOCK_50);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      ps2_dat = bits[i];
      idle(HALF);
      ps2_clk = 1'b0;
      idle(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    send_bits(make_frame(b, bad_par, stop), 0, 10);
    ps2_dat = 1'b1;
    idle(60);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_byte_data"}, 32'(byte_data), 32'h0);
    check({tag, "_pulses"}, 32'({byte_valid, parity_err, frame_err, key_valid}), 32'h0);
    check({tag, "_key_code"}, 32'(key_code), 32'h0);
    check({tag, "_key_flags"}, 32'({key_release, key_extended}), 32'h0);
  endtask

  initial begin
    int b0, p0, f0, k0;
    logic [10:0] fr;

    reset   = 1'b1;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    idle(5);
    @(negedge CLOCK_50);
    check_outputs_zero("reset");
    reset = 1'b0;
    idle(20);

    // Plain make code
    b0 = n_byte; k0 = n_key;
    send_frame(8'h1C, 1'b0, 1'b1);
    check("make_byte_cnt", 32'(n_byte - b0), 32'd1);
    check("make_byte_data", 32'(byte_data), 32'h1C);
    check("make_key_cnt", 32'(n_key - k0), 32'd1);
    check("make_key", 32'({key_code, key_release, key_extended}), {22'd0, 8'h1C, 2'b00});

    // Break code
    b0 = n_byte; k0 = n_key;
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    check("brk_byte_cnt", 32'(n_byte - b0), 32'd2);
    check("brk_key_cnt", 32'(n_key - k0), 32'd1);
    check("brk_key", 32'({key_code, key_release, key_extended}), {22'd0, 8'h1C, 2'b10});

    // Extended break code
    k0 = n_key;
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    check("ext_key_cnt", 32'(n_key - k0), 32'd1);
    check("ext_key", 32'({key_code, key_release, key_extended}), {22'd0, 8'h75, 2'b11});

    // Parity error, which also clears a pending break prefix
    send_frame(8'hF0, 1'b0, 1'b1);
    b0 = n_byte; p0 = n_par; f0 = n_frm; k0 = n_key;
    send_frame(8'h1A, 1'b1, 1'b1);
    check("par_err_cnt", 32'(n_par - p0), 32'd1);
    check("par_byte_cnt", 32'(n_byte - b0), 32'd0);
    check("par_frm_cnt", 32'(n_frm - f0), 32'd0);
    send_frame(8'h1A, 1'b0, 1'b1);
    check("par_next_key_cnt", 32'(n_key - k0), 32'd1);
    check("par_next_key", 32'({key_code, key_release, key_extended}), {22'd0, 8'h1A, 2'b00});

    // Bad stop bit, with good then bad parity
    b0 = n_byte; p0 = n_par; f0 = n_frm;
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0);
    check("stop_frm_cnt", 32'(n_frm - f0), 32'd2);
    check("stop_par_cnt", 32'(n_par - p0), 32'd0);
    check("stop_byte_cnt", 32'(n_byte - b0), 32'd0);

    // Timeout after start plus 3 data bits
    b0 = n_byte; f0 = n_frm; k0 = n_key;
    send_bits(make_frame(8'h1C, 1'b0, 1'b1), 0, 3);
    ps2_dat = 1'b1;
    idle(TO + 20);
    check("to_frm_cnt", 32'(n_frm - f0), 32'd1);
    check("to_byte_cnt", 32'(n_byte - b0), 32'd0);
    check("to_state_idle", 32'(dut.u_rx.state), 32'(ps2_pkg::ST_IDLE));
    idle(TO + 20);
    check("to_idle_no_err", 32'(n_frm - f0), 32'd1);
    send_frame(8'h2B, 1'b0, 1'b1);
    check("to_next_key_cnt", 32'(n_key - k0), 32'd1);
    check("to_next_key", 32'({key_code, key_release, key_extended}), {22'd0, 8'h2B, 2'b00});

    // One-cycle reset in the middle of a frame whose remaining bits are all 1
    fr = make_frame(8'hFF, 1'b0, 1'b1);
    b0 = n_byte; p0 = n_par; f0 = n_frm; k0 = n_key;
    send_bits(fr, 0, 3);
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    check_outputs_zero("midrst");
    reset = 1'b0;
    send_bits(fr, 4, 10);
    ps2_dat = 1'b1;
    idle(60);
    check("midrst_pulses", 32'((n_byte - b0) + (n_par - p0) + (n_frm - f0) + (n_key - k0)), 32'd0);
    send_frame(8'h1C, 1'b0, 1'b1);
    check("midrst_byte_cnt", 32'(n_byte - b0), 32'd1);
    check("midrst_key", 32'({key_code, key_release, key_extended}), {22'd0, 8'h1C, 2'b00});

    check("exclusive_pulses", 32'(n_excl), 32'd0);
    check("pulse_width", 32'(n_wide), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
